// File: rtl/knn_pipe_mac.sv
// knn_pipe_mac: pipelined multiply / multiply-accumulate for the kNN datapath.
// Per-beat signedness, optional accumulation, valid/ready flow control.
module knn_pipe_mac #(
  parameter int A_W    = 11,
  parameter int B_W    = 6,
  parameter int P_W    = 16,
  parameter int STAGES = 4,
  parameter int GUARD  = 4,
  parameter int SAT    = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] in_a,
  input  logic [B_W-1:0] in_b,
  input  logic           a_signed,
  input  logic           b_signed,
  input  logic           acc_en,
  input  logic           in_first,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P_W-1:0] out_data,
  output logic           out_ovf
);

  localparam int ACC_W = A_W + B_W + GUARD;
  localparam int PRD_W = A_W + B_W + 2;
  localparam int XW    = (ACC_W > P_W ? ACC_W : P_W) + 1;
  localparam int ND    = STAGES - 2;

  localparam logic signed [XW-1:0] HI_S =
    {{(XW-P_W+1){1'b0}}, {(P_W-1){1'b1}}};
  localparam logic signed [XW-1:0] HI_U =
    {{(XW-P_W){1'b0}}, {P_W{1'b1}}};
  localparam logic signed [XW-1:0] LO_S =
    {{(XW-P_W+1){1'b1}}, {(P_W-1){1'b0}}};

  logic adv;
  logic out_valid_q, out_valid_d;
  logic [P_W-1:0] data_q, data_d;
  logic ovf_q, ovf_d;

  // A single advance enable: the whole pipe holds when the output is stuck.
  assign adv       = !out_valid_q | out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_data  = data_q;
  assign out_ovf   = ovf_q;

  logic           s1_v_q, s1_v_d;
  logic [A_W-1:0] s1_a_q, s1_a_d;
  logic [B_W-1:0] s1_b_q, s1_b_d;
  logic           s1_as_q, s1_as_d;
  logic           s1_bs_q, s1_bs_d;
  logic           s1_acc_q, s1_acc_d;
  logic           s1_first_q, s1_first_d;
  logic           s1_last_q, s1_last_d;

  always_comb begin
    s1_v_d     = s1_v_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_as_d    = s1_as_q;
    s1_bs_d    = s1_bs_q;
    s1_acc_d   = s1_acc_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    if (adv) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        s1_a_d     = in_a;
        s1_b_d     = in_b;
        s1_as_d    = a_signed;
        s1_bs_d    = b_signed;
        s1_acc_d   = acc_en;
        s1_first_d = in_first;
        s1_last_d  = in_last;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v_q     <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_as_q    <= 1'b0;
      s1_bs_q    <= 1'b0;
      s1_acc_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_as_q    <= s1_as_d;
      s1_bs_q    <= s1_bs_d;
      s1_acc_q   <= s1_acc_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
    end
  end

  logic signed [A_W:0]   ax;
  logic signed [B_W:0]   bx;
  logic signed [PRD_W-1:0] prod;
  logic [ACC_W-1:0] prod_x, sum, r0;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic e0, sg0;

  always_comb begin
    ax     = {s1_as_q & s1_a_q[A_W-1], s1_a_q};
    bx     = {s1_bs_q & s1_b_q[B_W-1], s1_b_q};
    prod   = PRD_W'(ax) * PRD_W'(bx);
    prod_x = ACC_W'(prod);
    sum    = (s1_first_q ? '0 : acc_q) + prod_x;
    r0     = s1_acc_q ? sum : prod_x;
    e0     = s1_v_q & (!s1_acc_q | s1_last_q);
    sg0    = s1_as_q | s1_bs_q;
    acc_d  = acc_q;
    if (adv && s1_v_q && s1_acc_q)
      acc_d = s1_last_q ? '0 : sum;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  logic             tl_e, tl_s;
  logic [ACC_W-1:0] tl_r;

  if (ND > 0) begin : g_dly
    logic [ND-1:0]    e_q, e_d;
    logic [ND-1:0]    s_q, s_d;
    logic [ACC_W-1:0] r_q [ND];
    logic [ACC_W-1:0] r_d [ND];

    always_comb begin
      e_d = e_q;
      s_d = s_q;
      r_d = r_q;
      if (adv) begin
        e_d[0] = e0;
        s_d[0] = sg0;
        r_d[0] = r0;
        for (int i = 1; i < ND; i++) begin
          e_d[i] = e_q[i-1];
          s_d[i] = s_q[i-1];
          r_d[i] = r_q[i-1];
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        e_q <= '0;
        s_q <= '0;
        r_q <= '{default: '0};
      end else begin
        e_q <= e_d;
        s_q <= s_d;
        r_q <= r_d;
      end
    end

    assign tl_e = e_q[ND-1];
    assign tl_s = s_q[ND-1];
    assign tl_r = r_q[ND-1];
  end else begin : g_nodly
    assign tl_e = e0;
    assign tl_s = sg0;
    assign tl_r = r0;
  end

  logic signed [XW-1:0] rx, hi, lo;
  logic [P_W-1:0] dat_n;
  logic ovf_n;

  // Range check in a width wide enough for both signed and unsigned views.
  always_comb begin
    rx = tl_s ? {{(XW-ACC_W){tl_r[ACC_W-1]}}, tl_r}
              : {{(XW-ACC_W){1'b0}}, tl_r};
    hi = tl_s ? HI_S : HI_U;
    lo = tl_s ? LO_S : '0;
    ovf_n = (rx > hi) | (rx < lo);
    dat_n = rx[P_W-1:0];
    if (SAT != 0 && rx > hi)
      dat_n = hi[P_W-1:0];
    else if (SAT != 0 && rx < lo)
      dat_n = lo[P_W-1:0];
  end

  always_comb begin
    out_valid_d = out_valid_q;
    data_d      = data_q;
    ovf_d       = ovf_q;
    if (adv) begin
      out_valid_d = tl_e;
      if (tl_e) begin
        data_d = dat_n;
        ovf_d  = ovf_n;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_knn_pipe_mac.sv
// tb_knn_pipe_mac: scoreboard bench for knn_pipe_mac.
// A SAT=0 and a SAT=1 instance share the same stimulus.
module tb_knn_pipe_mac;

  localparam int ST = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready, in_ready_s;
  logic [10:0] in_a = '0;
  logic [5:0]  in_b = '0;
  logic        a_signed = 1'b0;
  logic        b_signed = 1'b0;
  logic        acc_en = 1'b0;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic        out_valid, out_valid_s;
  logic        out_ready = 1'b1;
  logic [15:0] out_data, out_data_s;
  logic        out_ovf, out_ovf_s;

  int compared = 0;
  int mismatched = 0;

  logic [16:0] obs_q[$], obs_s_q[$], exp_q[$], exp_s_q[$];

  always #5 clk = ~clk;

  knn_pipe_mac #(.SAT(0)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .a_signed(a_signed), .b_signed(b_signed),
    .acc_en(acc_en), .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  knn_pipe_mac #(.SAT(1)) dut_s (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready_s),
    .in_a(in_a), .in_b(in_b),
    .a_signed(a_signed), .b_signed(b_signed),
    .acc_en(acc_en), .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .out_ovf(out_ovf_s)
  );

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready)
        obs_q.push_back({out_ovf, out_data});
      if (out_valid_s && out_ready)
        obs_s_q.push_back({out_ovf_s, out_data_s});
    end
  end

  function automatic longint prod(logic [10:0] a, logic [5:0] b,
                                  bit as_, bit bs_);
    longint av, bv;
    av = as_ ? longint'($signed(a)) : longint'(a);
    bv = bs_ ? longint'($signed(b)) : longint'(b);
    return av * bv;
  endfunction

  function automatic logic [16:0] model(longint r, bit sg, bit sat);
    longint hi, lo, v;
    hi = sg ? 32767 : 65535;
    lo = sg ? -32768 : 0;
    v = r;
    if (sat && r > hi) v = hi;
    else if (sat && r < lo) v = lo;
    return {(r > hi) || (r < lo), v[15:0]};
  endfunction

  task automatic clear_sb();
    obs_q.delete(); obs_s_q.delete();
    exp_q.delete(); exp_s_q.delete();
  endtask

  task automatic drive(input logic [10:0] a, input logic [5:0] b,
                       input bit as_, bs_, ac, f, l);
    bit took;
    int n;
    in_valid = 1'b1; in_a = a; in_b = b;
    a_signed = as_; b_signed = bs_;
    acc_en = ac; in_first = f; in_last = l;
    took = 1'b0; n = 0;
    while (!took && n < 100) begin
      @(negedge clk); took = in_ready;
      @(posedge clk); #1; n++;
    end
    if (!took) begin
      compared++; mismatched++;
      $display("FAIL drive_timeout a=%0d b=%0d never accepted", a, b);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++; $display("FAIL rst_hold_valid got %b want 0", out_valid);
    end
    reset = 1'b0;
    #1;
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++; $display("FAIL rst_valid got %b want 0", out_valid);
    end
    compared++;
    if (out_data !== 16'h0 || out_ovf !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_data got %h/%b want 0000/0", out_data, out_ovf);
    end
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++; $display("FAIL rst_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_latency();
    int n;
    clear_sb();
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 11'd100; in_b = 6'd50;
    a_signed = 1'b0; b_signed = 1'b0;
    acc_en = 1'b0; in_first = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    compared++;
    if (n !== ST - 1) begin
      mismatched++; $display("FAIL latency got %0d want %0d", n + 1, ST);
    end
    compared++;
    if (out_data !== 16'd5000 || out_ovf !== 1'b0) begin
      mismatched++;
      $display("FAIL lat_data got %0d/%b want 5000/0", out_data, out_ovf);
    end
    repeat (3) @(posedge clk); #1;
    clear_sb();
  endtask

  task automatic test_overflow();
    logic [16:0] o, e;
    int n;
    clear_sb();
    exp_q.push_back({1'b1, 16'd63425}); exp_s_q.push_back({1'b1, 16'd65535});
    drive(11'd2047, 6'd63, 0, 0, 0, 0, 0);
    exp_q.push_back({1'b1, 16'h8000}); exp_s_q.push_back({1'b1, 16'h7FFF});
    drive(11'h400, 6'h20, 1, 1, 0, 0, 0);
    exp_q.push_back({1'b1, 16'h0020}); exp_s_q.push_back({1'b1, 16'h8000});
    drive(11'd2047, 6'h20, 0, 1, 0, 0, 0);
    exp_q.push_back({1'b0, 16'd32767}); exp_s_q.push_back({1'b0, 16'd32767});
    drive(11'd1057, 6'd31, 0, 0, 0, 0, 0);
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 200) begin
      @(posedge clk); #1; n++;
    end
    repeat (ST + 2) @(posedge clk); #1;
    compared++;
    if (obs_q.size() !== exp_q.size() || obs_s_q.size() !== exp_s_q.size()) begin
      mismatched++;
      $display("FAIL ovf_count got %0d/%0d want %0d", obs_q.size(),
               obs_s_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      compared++;
      if (o !== e) begin
        mismatched++;
        $display("FAIL ovf_wrap got %b/%h want %b/%h", o[16], o[15:0], e[16], e[15:0]);
      end
    end
    while (obs_s_q.size() > 0 && exp_s_q.size() > 0) begin
      o = obs_s_q.pop_front(); e = exp_s_q.pop_front();
      compared++;
      if (o !== e) begin
        mismatched++;
        $display("FAIL ovf_sat got %b/%h want %b/%h", o[16], o[15:0], e[16], e[15:0]);
      end
    end
  endtask

  task automatic test_signed();
    logic [16:0] o, e;
    int n;
    clear_sb();
    exp_q.push_back({1'b0, 16'hFFF1});
    drive(11'h7FD, 6'd5, 1, 0, 0, 0, 0);
    exp_q.push_back({1'b0, 16'h000F});
    drive(11'h7FD, 6'h3B, 1, 1, 0, 0, 0);
    exp_q.push_back({1'b0, 16'hFFF7});
    drive(11'h7FD, 6'd5, 1, 0, 1, 1, 0);
    drive(11'd2, 6'd3, 1, 0, 1, 0, 1);
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 200) begin
      @(posedge clk); #1; n++;
    end
    repeat (ST + 2) @(posedge clk); #1;
    compared++;
    if (obs_q.size() !== exp_q.size()) begin
      mismatched++;
      $display("FAIL sgn_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      compared++;
      if (o !== e) begin
        mismatched++;
        $display("FAIL sgn_data got %b/%h want %b/%h", o[16], o[15:0], e[16], e[15:0]);
      end
    end
  endtask

  task automatic test_accumulate();
    logic [16:0] o, e;
    int n;
    clear_sb();
    drive(11'd10, 6'd3, 0, 0, 1, 1, 0);
    drive(11'd20, 6'd2, 0, 0, 1, 0, 0);
    drive(11'd7, 6'd1, 0, 0, 1, 0, 1);
    repeat (ST + 4) @(posedge clk); #1;
    compared++;
    if (obs_q.size() !== 1) begin
      mismatched++; $display("FAIL acc_one got %0d results want 1", obs_q.size());
    end
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      compared++;
      if (o !== {1'b0, 16'd77}) begin
        mismatched++; $display("FAIL acc_sum got %0d want 77", o[15:0]);
      end
    end
    clear_sb();
    exp_q.push_back({1'b0, 16'd16});
    drive(11'd4, 6'd4, 0, 0, 1, 1, 1);
    exp_q.push_back({1'b0, 16'd6});
    drive(11'd5, 6'd5, 0, 0, 1, 1, 0);
    drive(11'd2, 6'd3, 0, 0, 1, 1, 1);
    exp_q.push_back({1'b0, 16'd11});
    drive(11'd3, 6'd3, 0, 0, 1, 0, 0);
    drive(11'd1, 6'd2, 0, 0, 1, 0, 1);
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 200) begin
      @(posedge clk); #1; n++;
    end
    repeat (ST + 2) @(posedge clk); #1;
    compared++;
    if (obs_q.size() !== exp_q.size()) begin
      mismatched++;
      $display("FAIL acc_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      compared++;
      if (o !== e) begin
        mismatched++;
        $display("FAIL acc_data got %b/%0d want %b/%0d", o[16], o[15:0], e[16], e[15:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [16:0] o, e;
    int n;
    clear_sb();
    out_ready = 1'b1;
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          exp_q.push_back({1'b0, 16'(k)});
          drive(11'(k), 6'd1, 0, 0, 0, 0, 0);
        end
      end
      begin
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          compared++;
          if (in_ready !== 1'b0) begin
            mismatched++; $display("FAIL bp_ready got %b want 0", in_ready);
          end
          compared++;
          if (out_valid !== 1'b1 || out_data !== 16'd1) begin
            mismatched++;
            $display("FAIL bp_hold got %b/%0d want 1/1", out_valid, out_data);
          end
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 200) begin
      @(posedge clk); #1; n++;
    end
    repeat (ST + 2) @(posedge clk); #1;
    compared++;
    if (obs_q.size() !== exp_q.size()) begin
      mismatched++;
      $display("FAIL bp_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      compared++;
      if (o !== e) begin
        mismatched++; $display("FAIL bp_order got %0d want %0d", o[15:0], e[15:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] o, e;
    logic [10:0] a;
    logic [5:0]  b;
    bit as_, bs_;
    longint p;
    int n;
    clear_sb();
    fork
      begin
        for (int k = 0; k < 24; k++) begin
          a = 11'($urandom_range(0, 2047));
          b = 6'($urandom_range(0, 63));
          as_ = 1'($urandom_range(0, 1));
          bs_ = 1'($urandom_range(0, 1));
          p = prod(a, b, as_, bs_);
          exp_q.push_back(model(p, as_ | bs_, 1'b0));
          exp_s_q.push_back(model(p, as_ | bs_, 1'b1));
          drive(a, b, as_, bs_, 0, 0, 0);
        end
      end
      begin
        repeat (80) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 200) begin
      @(posedge clk); #1; n++;
    end
    repeat (ST + 2) @(posedge clk); #1;
    compared++;
    if (obs_q.size() !== exp_q.size() || obs_s_q.size() !== exp_s_q.size()) begin
      mismatched++;
      $display("FAIL b2b_count got %0d/%0d want %0d", obs_q.size(),
               obs_s_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      compared++;
      if (o !== e) begin
        mismatched++;
        $display("FAIL b2b_wrap got %b/%h want %b/%h", o[16], o[15:0], e[16], e[15:0]);
      end
    end
    while (obs_s_q.size() > 0 && exp_s_q.size() > 0) begin
      o = obs_s_q.pop_front(); e = exp_s_q.pop_front();
      compared++;
      if (o !== e) begin
        mismatched++;
        $display("FAIL b2b_sat got %b/%h want %b/%h", o[16], o[15:0], e[16], e[15:0]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    int n;
    clear_sb();
    drive(11'd3, 6'd3, 0, 0, 1, 1, 0);
    drive(11'd9, 6'd9, 0, 0, 0, 0, 0);
    drive(11'd8, 6'd8, 0, 0, 0, 0, 0);
    drive(11'd7, 6'd7, 0, 0, 0, 0, 0);
    drive(11'd6, 6'd6, 0, 0, 0, 0, 0);
    compared++;
    if (out_valid !== 1'b1) begin
      mismatched++; $display("FAIL mid_pre got %b want 1", out_valid);
    end
    #2 reset = 1'b1;
    #1;
    compared++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || out_ovf !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_rst got %b/%h/%b want 0/0000/0", out_valid, out_data, out_ovf);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_sb();
    repeat (10) @(posedge clk); #1;
    compared++;
    if (obs_q.size() !== 0) begin
      mismatched++; $display("FAIL mid_stale got %0d results want 0", obs_q.size());
    end
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++; $display("FAIL mid_ready got %b want 1", in_ready);
    end
    drive(11'd2, 6'd2, 0, 0, 1, 0, 1);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    compared++;
    if (n !== ST - 1) begin
      mismatched++; $display("FAIL mid_lat got %0d want %0d", n + 1, ST);
    end
    compared++;
    if (out_data !== 16'd4 || out_ovf !== 1'b0) begin
      mismatched++; $display("FAIL mid_fresh got %0d want 4", out_data);
    end
    repeat (3) @(posedge clk); #1;
    clear_sb();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_overflow();
    test_signed();
    test_accumulate();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
